// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the writeback port arbiter and its 3-way pickers.
package wb_port_arbiter_pkg;
  localparam int DATA_W = 16;
  localparam int REG_AW = 3;

  typedef enum logic [1:0] {
    WB_SRC_ALU  = 2'b00,
    WB_SRC_LOAD = 2'b01,
    WB_SRC_LINK = 2'b10,
    WB_SRC_NONE = 2'b11
  } wb_src_e;

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction
endpackage

// File: rtl/wb_port_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker: first valid bit at or after ptr, wrapping 2->0.
module rr_pick3 (
  input  logic [2:0] valid,
  input  logic [1:0] ptr,
  output logic [2:0] grant,
  output logic [1:0] idx,
  output logic       any_grant
);
  always_comb begin
    grant     = '0;
    idx       = 2'b11;
    any_grant = 1'b0;
    for (int k = 0; k < 3; k++) begin
      int p;
      p = (int'(ptr) + k) % 3;
      if (!any_grant && valid[p]) begin
        grant[p]  = 1'b1;
        idx       = 2'(p);
        any_grant = 1'b1;
      end
    end
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: round-robin over ALU/load/link, one-deep writeback stage,
// saturating contention counter.
module wb_port_arbiter #(
  parameter int DATA_W = wb_port_arbiter_pkg::DATA_W,
  parameter int REG_AW = wb_port_arbiter_pkg::REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        req_valid,
  output logic [2:0]        req_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [DATA_W-1:0] req2_data,
  input  logic [REG_AW-1:0] req0_rd,
  input  logic [REG_AW-1:0] req1_rd,
  input  logic [REG_AW-1:0] req2_rd,
  input  logic              wb_stall,
  output logic [1:0]        mux_sel,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  conflict_cnt
);
  import wb_port_arbiter_pkg::*;

  logic [1:0]        rr_ptr;
  logic [2:0]        grant;
  logic [1:0]        idx;
  logic              any_grant;
  logic              xfer;
  wb_src_e           src;
  logic [DATA_W-1:0] sel_data;
  logic [REG_AW-1:0] sel_rd;

  rr_pick3 u_pick (
    .valid     (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .idx       (idx),
    .any_grant (any_grant)
  );

  // Select tracks the grant even under stall so the mux settles early.
  assign src       = (rst_n && any_grant) ? wb_src_e'(idx) : WB_SRC_NONE;
  assign mux_sel   = src;
  assign req_ready = (rst_n && !wb_stall) ? grant : 3'b000;
  assign xfer      = |(req_valid & req_ready);

  always_comb begin
    sel_data = '0;
    sel_rd   = '0;
    case (src)
      WB_SRC_ALU:  begin sel_data = req0_data; sel_rd = req0_rd; end
      WB_SRC_LOAD: begin sel_data = req1_data; sel_rd = req1_rd; end
      WB_SRC_LINK: begin sel_data = req2_data; sel_rd = req2_rd; end
      default:     begin sel_data = '0;        sel_rd = '0;      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr  <= 2'd0;
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else if (!wb_stall) begin
      if (xfer) begin
        rr_ptr  <= rr_next(idx);
        wb_we   <= (sel_rd != '0);
        wb_addr <= sel_rd;
        wb_data <= sel_data;
      end else begin
        wb_we   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      conflict_cnt <= '0;
    end else if ($countones(req_valid) >= 2 && !(&conflict_cnt)) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end
endmodule
